share_memory_mp: RTL and testbench
==================================

Name: share_memory_mp

Overview:
- N-port shared single-bank SRAM with round-robin arbitration, byte-enabled writes and registered read responses.
- Next generation of the two-port PE/AXI shared memory: generalised port count, width and depth, with fair arbitration, a valid/ready handshake and range checking.
- Sits between PE lanes, AXI slave bridges and DMA, and any of them as requesters.

Parameters:
- NUM_PORTS, 4, number of requester ports (>=2).
- DEPTH, 256, memory words (need not be a power of 2).
- WIDTH, 32, data width in bits (multiple of 8).
- ADDR_W, 8, address width; must satisfy 2**ADDR_W >= DEPTH.
- BE_W, WIDTH/8, byte-enable width (derived).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port grant, one-hot or zero.
- req_we  in  NUM_PORTS  per-port write (1) / read (0).
- req_addr  in  NUM_PORTS*ADDR_W  flattened addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*WIDTH  flattened write data.
- req_be  in  NUM_PORTS*BE_W  flattened byte enables.
- rsp_valid  out  NUM_PORTS  per-port response pulse.
- rsp_rdata  out  WIDTH  shared read data, qualified by rsp_valid.
- rsp_err  out  1  response error flag, qualified by rsp_valid.

Behaviour:
- Reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, priority pointer=0. Memory contents are not reset.
- Arbitration (combinational):
  - Search req_valid starting at pointer, wrapping modulo NUM_PORTS.
  - The first asserted port gets req_ready=1; all others get 0.
  - req_ready never asserts without the matching req_valid.
- Accept: valid&&ready at the rising edge. At most one accept per cycle.
- Pointer update: on accept, pointer <= granted+1, wrapping NUM_PORTS-1 -> 0. With no accept the pointer holds.
- Fairness: a port holding req_valid is accepted within NUM_PORTS cycles.
- Write accept:
  - mem[addr] byte lane b is updated iff be[b]; other lanes keep their value.
  - be=0 is legal: no update, response still issued.
- Read accept: rsp_rdata <= mem[addr] at the same edge, giving read latency 1.
- Read-during-write: impossible (single accept per cycle). A read accepted the cycle after a write to the same address returns the new data.
- Response:
  - The cycle after an accept, rsp_valid is one-hot on the accepted port for exactly 1 cycle; otherwise 0.
  - Writes also get a response, with rsp_rdata=0.
  - There is no backpressure on responses.
- Range check: addr >= DEPTH → write suppressed, read data=0, rsp_err=1. rsp_err=0 otherwise.
- Requester rules:
  - Once asserted, req_valid and its payload must stay stable until accepted.
  - A requester may issue back-to-back requests; a new request is accepted the same cycle its previous response is returned.
- Mid-operation reset: a pending response is dropped. rsp_valid is 0 during and after reset until a new accept.
- Idle cycles (no req_valid): no memory access, rsp_valid=0, rsp_rdata holds its last value.

Decomposition:
- Package share_mem_pkg:
  - default NUM_PORTS/DEPTH/WIDTH constants;
  - a function returning the one-hot grant from a request vector and pointer;
  - a localparam for the pointer width, $clog2(NUM_PORTS).
- Sub-module rr_arbiter:
  - parameter N;
  - inputs clk, rst_n, req[N], accept;
  - outputs grant[N] and grant_idx.
  - Holds the pointer; reused by future DMA and NoC blocks.
- The top module holds the memory array, write byte-masking, range check and response register.

Test Plan:
- Reset, then port 1 writes 0xDEADBEEF to addr 0x10 with be=4'hF; port 1 reads 0x10 → rsp_valid[1] one cycle after read accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte enables: write 0xFFFFFFFF, then 0x00000000 with be=4'b0101, then read → 0xFF00FF00.
- All 4 ports hold req_valid for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3; each port accepted exactly twice.
- Only port 2 requests continuously for 3 cycles, then port 0 joins → port 2 accepted in cycles 1-3, then port 0 accepted next; no cycle without a grant.
- DEPTH=200: write 0x1234 to addr 0xC8 → rsp_err=1 and memory unchanged; read addr 0xC8 → rdata=0, rsp_err=1; read addr 0xC7 → rsp_err=0.
- Assert rst_n=0 the cycle after a read accept → rsp_valid stays 0 and the pointer returns to 0; the first request after release from ports {1,3} is granted to port 1.

Source files
------------

// File: rtl/share_mem_pkg.sv
// Shared-memory package: default sizing constants and the round-robin grant helper.
package share_mem_pkg;

    localparam int unsigned NUM_PORTS_DEF = 4;
    localparam int unsigned DEPTH_DEF     = 256;
    localparam int unsigned WIDTH_DEF     = 32;
    localparam int unsigned ADDR_W_DEF    = 8;
    localparam int unsigned PTR_W         = $clog2(NUM_PORTS_DEF);

    // Widest request vector the grant helper handles; callers zero-extend.
    localparam int unsigned MAX_PORTS     = 32;
    localparam int unsigned MAX_IDX_W     = 5;

    // One-hot grant: first set bit of req[0..n-1] searching upward from ptr, wrapping at n.
    function automatic logic [MAX_PORTS-1:0] rr_grant(
        input logic [MAX_PORTS-1:0] req,
        input int unsigned          n,
        input int unsigned          ptr
    );
        logic [MAX_PORTS-1:0] g;
        logic                 found;
        int unsigned          idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (i < n && !found) begin
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[MAX_IDX_W-1:0]]) begin
                    g[idx[MAX_IDX_W-1:0]] = 1'b1;
                    found                 = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/share_memory_mp_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports: clk, rst_n, req[N] requests, accept (grant taken this edge),
//        grant[N] one-hot or zero (combinational), grant_idx encoded grant.
module rr_arbiter
    import share_mem_pkg::*;
#(
    parameter  int unsigned N     = NUM_PORTS_DEF,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             accept,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] r_ptr;

    // Grant search starts at the pointer and wraps modulo N.
    always_comb begin
        grant     = N'(rr_grant(MAX_PORTS'(req), N, 32'(r_ptr)));
        grant_idx = '0;
        for (int unsigned p = 0; p < N; p++) begin
            if (grant[p]) begin
                grant_idx = IDX_W'(p);
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (accept) begin
            if (grant_idx == IDX_W'(N - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/share_memory_mp.sv
// N-port shared single-bank SRAM: round-robin arbitration, byte-enabled writes,
// range check and a registered one-cycle response.
// Ports: clk, rst_n; req_valid/req_ready/req_we per port; flattened req_addr,
//        req_wdata, req_be; rsp_valid per port; shared rsp_rdata and rsp_err.
module share_memory_mp
    import share_mem_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter  int unsigned DEPTH     = DEPTH_DEF,
    parameter  int unsigned WIDTH     = WIDTH_DEF,
    parameter  int unsigned ADDR_W    = ADDR_W_DEF,
    localparam int unsigned BE_W      = WIDTH / 8,
    localparam int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int unsigned MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*WIDTH-1:0]  req_wdata,
    input  logic [NUM_PORTS*BE_W-1:0]   req_be,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [WIDTH-1:0]            rsp_rdata,
    output logic                        rsp_err
);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [NUM_PORTS-1:0] r_rsp_valid;
    logic [WIDTH-1:0]     r_rsp_rdata;
    logic                 r_rsp_err;

    logic [NUM_PORTS-1:0] w_grant;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_accept;
    logic                 w_we;
    logic [ADDR_W-1:0]    w_addr;
    logic [WIDTH-1:0]     w_wdata;
    logic [BE_W-1:0]      w_be;
    logic                 w_in_range;
    logic [MEM_AW-1:0]    w_mem_idx;

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .accept    (w_accept),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // No grant is visible while reset is held.
    assign req_ready = w_grant & {NUM_PORTS{rst_n}};
    assign w_accept  = |(req_valid & req_ready);

    // Winning port's payload.
    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_grant_idx == IDX_W'(p)) begin
                w_we    = req_we[p];
                w_addr  = req_addr[p*ADDR_W +: ADDR_W];
                w_wdata = req_wdata[p*WIDTH +: WIDTH];
                w_be    = req_be[p*BE_W +: BE_W];
            end
        end
    end

    assign w_in_range = 32'(w_addr) < DEPTH;
    assign w_mem_idx  = MEM_AW'(w_addr);

    // Byte-masked write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_accept && w_we && w_in_range) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (w_be[b]) begin
                    r_mem[w_mem_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Response: one-cycle pulse on the accepted port; rdata holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= req_ready;
            r_rsp_err   <= !w_in_range;
            r_rsp_rdata <= (w_we || !w_in_range) ? '0 : r_mem[w_mem_idx];
        end else begin
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_share_memory_mp.sv
// Self-checking bench for share_memory_mp (DEPTH=200 so the range check is exercised).
module tb_share_memory_mp;

    localparam int unsigned NP     = 4;
    localparam int unsigned DEPTH  = 200;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned BE_W   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NP-1:0]        req_valid;
    logic [NP-1:0]        req_ready;
    logic [NP-1:0]        req_we;
    logic [NP*ADDR_W-1:0] req_addr;
    logic [NP*WIDTH-1:0]  req_wdata;
    logic [NP*BE_W-1:0]   req_be;
    logic [NP-1:0]        rsp_valid;
    logic [WIDTH-1:0]     rsp_rdata;
    logic                 rsp_err;

    share_memory_mp #(
        .NUM_PORTS (NP),
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] m_mem [256];
    int          m_ptr;
    int          exp_g;
    logic [3:0]  exp_valid;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          acc_q [$];

    // Requester state.
    logic        v   [NP];
    logic        wea [NP];
    logic [7:0]  ad  [NP];
    logic [31:0] wd  [NP];
    logic [3:0]  bea [NP];
    int          wt  [NP];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            req_valid[p]             = v[p];
            req_we[p]                = wea[p];
            req_addr[p*ADDR_W +: 8]  = ad[p];
            req_wdata[p*WIDTH +: 32] = wd[p];
            req_be[p*BE_W +: 4]      = bea[p];
        end
    endtask

    task automatic set_req(input int p, input logic we, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        v[p] = 1'b1; wea[p] = we; ad[p] = a; wd[p] = d; bea[p] = be; wt[p] = 0;
    endtask

    task automatic clear_reqs();
        for (int p = 0; p < NP; p++) begin
            v[p] = 1'b0; wea[p] = 1'b0; ad[p] = '0; wd[p] = '0; bea[p] = '0; wt[p] = 0;
        end
    endtask

    function automatic int model_grant();
        for (int i = 0; i < NP; i++) begin
            if (v[(m_ptr + i) % NP]) return (m_ptr + i) % NP;
        end
        return -1;
    endfunction

    // Apply requests, then compare the combinational grant against the model.
    task automatic check_grant();
        logic [3:0] eg;
        drive();
        #1;
        exp_g = model_grant();
        eg    = (exp_g >= 0) ? 4'(1 << exp_g) : 4'b0;
        chk("req_ready", 32'(req_ready), 32'(eg));
    endtask

    // Clock edge, then advance the model and compare the response.
    task automatic tick();
        int          p;
        logic [7:0]  a;
        logic        inr;
        @(posedge clk);
        #1;
        for (int q = 0; q < NP; q++) begin
            if (v[q] && q != exp_g) wt[q]++;
        end
        if (exp_g >= 0) begin
            p   = exp_g;
            a   = ad[p];
            inr = (int'(a) < DEPTH);
            acc_q.push_back(p);
            chk("fair_wait", 32'(wt[p] <= NP - 1), 32'd1);
            if (wea[p]) begin
                if (inr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bea[p][b]) m_mem[a][b*8 +: 8] = wd[p][b*8 +: 8];
                    end
                end
                exp_rdata = '0;
            end else begin
                exp_rdata = inr ? m_mem[a] : 32'h0;
            end
            exp_err   = !inr;
            exp_valid = 4'(1 << p);
            m_ptr     = (p + 1) % NP;
            v[p]      = 1'b0;
            wt[p]     = 0;
        end else begin
            exp_valid = '0;
            exp_err   = 1'b0;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    endtask

    task automatic step();
        check_grant();
        tick();
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        exp_g     = -1;
        exp_valid = '0;
        exp_rdata = '0;
        exp_err   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        drive();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_t4 [4]    = '{2, 2, 2, 0};
        int cnt [NP];

        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        clear_reqs();
        model_reset();

        // Reset state, with every port requesting during reset.
        rst_n = 1'b0;
        for (int p = 0; p < NP; p++) set_req(p, 1'b1, 8'(p), 32'hA5A5_0000 + 32'(p), 4'hF);
        drive();
        #12;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 32'(rsp_valid), 32'd0);
        do_reset();

        // Basic write/read on port 1.
        set_req(1, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF);
        step();
        chk("t1_wr_rdata_zero", rsp_rdata, 32'd0);
        set_req(1, 1'b0, 8'h10, 32'h0, 4'h0);
        step();
        chk("t1_rd_valid", 32'(rsp_valid), 32'h2);
        chk("t1_rd_data", rsp_rdata, 32'hDEAD_BEEF);
        chk("t1_rd_err", 32'(rsp_err), 32'd0);
        clear_reqs();
        step();
        chk("idle_hold_rdata", rsp_rdata, 32'hDEAD_BEEF);

        // Byte enables, including be=0.
        set_req(0, 1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF);
        step();
        set_req(0, 1'b1, 8'h20, 32'h0000_0000, 4'b0101);
        step();
        set_req(0, 1'b0, 8'h20, 32'h0, 4'h0);
        step();
        chk("be_rdata", rsp_rdata, 32'hFF00_FF00);
        set_req(3, 1'b1, 8'h20, 32'h1234_5678, 4'h0);
        step();
        chk("be0_valid", 32'(rsp_valid), 32'h8);
        set_req(3, 1'b0, 8'h20, 32'h0, 4'h0);
        step();
        chk("be0_rdata", rsp_rdata, 32'hFF00_FF00);

        // Range check at DEPTH boundary.
        set_req(2, 1'b1, 8'hC7, 32'h0000_C7C7, 4'hF);
        step();
        set_req(2, 1'b1, 8'hC8, 32'h0000_1234, 4'hF);
        step();
        chk("oor_wr_err", 32'(rsp_err), 32'd1);
        set_req(2, 1'b0, 8'hC8, 32'h0, 4'h0);
        step();
        chk("oor_rd_err", 32'(rsp_err), 32'd1);
        chk("oor_rd_data", rsp_rdata, 32'd0);
        set_req(2, 1'b0, 8'hC7, 32'h0, 4'h0);
        step();
        chk("inr_rd_err", 32'(rsp_err), 32'd0);
        chk("inr_rd_data", rsp_rdata, 32'h0000_C7C7);

        // Port 2 alone for three cycles, then port 0 joins.
        acc_q.delete();
        for (int i = 0; i < 4; i++) begin
            set_req(2, 1'b0, 8'(8'h40 + 8'(i)), 32'h0, 4'h0);
            if (i == 3) set_req(0, 1'b0, 8'h10, 32'h0, 4'h0);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t4_order", 32'(acc_q[i]), 32'(exp_t4[i]));
        end
        step();

        // Fill memory with known data from port 0.
        clear_reqs();
        for (int a = 0; a < DEPTH; a++) begin
            set_req(0, 1'b1, 8'(a), $urandom, 4'hF);
            step();
        end

        // Reset right after a read accept: response dropped, pointer back to 0.
        clear_reqs();
        set_req(2, 1'b0, 8'h33, 32'h0, 4'h0);
        check_grant();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_reqs();
        drive();
        model_reset();
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_valid2", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        set_req(1, 1'b0, 8'h05, 32'h0, 4'h0);
        set_req(3, 1'b0, 8'h06, 32'h0, 4'h0);
        check_grant();
        chk("post_rst_grant", 32'(req_ready), 32'h2);
        tick();
        step();

        // All ports requesting continuously from reset.
        do_reset();
        acc_q.delete();
        for (int p = 0; p < NP; p++) set_req(p, 1'($urandom), 8'($urandom_range(0, DEPTH - 1)), $urandom, 4'($urandom));
        for (int i = 0; i < 8; i++) begin
            step();
            for (int p = 0; p < NP; p++) begin
                if (!v[p]) set_req(p, 1'($urandom), 8'($urandom_range(0, DEPTH - 1)), $urandom, 4'($urandom));
            end
        end
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        for (int i = 0; i < 8; i++) begin
            chk("t5_order", 32'(acc_q[i]), 32'(exp_order[i]));
            cnt[acc_q[i]]++;
        end
        for (int p = 0; p < NP; p++) chk("t5_count", 32'(cnt[p]), 32'd2);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (!v[p] && ($urandom % 2 == 0)) begin
                    set_req(p, 1'($urandom), 8'($urandom_range(0, 215)), $urandom, 4'($urandom));
                end
            end
            step();
        end
        clear_reqs();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
